// File: rtl/array_alu_rd_master.sv
// array_alu_rd_master: AXI4 read master that drains array_alu results and streams them in address order
// Ports:
//   clk, areset            : clock, synchronous active-high reset
//   start/base_addr/count  : command strobe, first address, beat count (sampled in IDLE)
//   busy/done/err          : status, one-cycle done pulse, sticky error
//   ar*                    : AXI AR channel, arid = slot index = beat mod 2**ID_W
//   r*                     : AXI R channel, rready = busy (slots are always reserved)
//   out_*                  : in-order valid/ready result stream
// Build option: ARRAY_ALU_RD_RRESP_CHECK_EN propagates non-OKAY rresp to out_err and err.
module array_alu_rd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);
    localparam int S = 2 ** ID_W;
`ifdef ARRAY_ALU_RD_RRESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt, iss, head;
    logic [S-1:0]      pend, fill, serr;
    logic [DATA_W-1:0] data [S];
    logic [ID_W-1:0]   is, hs;
    logic              ar_hs, r_hs, out_hs, last_ar, last_out;

    assign is       = iss[ID_W-1:0];
    assign hs       = head[ID_W-1:0];
    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign out_hs   = out_valid && out_ready;
    assign last_ar  = iss == cnt - CNT_W'(1);
    assign last_out = head == cnt - CNT_W'(1);

    // AR outputs derive from registered state only, so they hold until arready
    // and a slot freed at an edge is reissued no earlier than the next cycle.
    assign busy      = state != IDLE;
    assign rready    = busy;
    assign done      = state == DONE;
    assign arvalid   = state == ISSUE && !pend[is] && !fill[is];
    assign arid      = is;
    assign araddr    = base + (ADDR_W'(iss) << 2);
    assign out_valid = fill[hs];
    assign out_data  = data[hs];
    assign out_err   = serr[hs];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (count == '0) ? DONE : ISSUE;
            ISSUE:   if (ar_hs && last_ar) state_n = DRAIN;
            DRAIN:   if (out_hs && last_out) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
            base  <= '0;
            cnt   <= '0;
            iss   <= '0;
            head  <= '0;
            pend  <= '0;
            fill  <= '0;
            serr  <= '0;
            err   <= 1'b0;
            for (int i = 0; i < S; i++) data[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                base <= base_addr;
                cnt  <= count;
                iss  <= '0;
                head <= '0;
                err  <= 1'b0;
            end
            if (ar_hs) begin
                pend[is] <= 1'b1;
                iss      <= iss + CNT_W'(1);
            end
            if (r_hs) begin
                if (pend[rid]) begin
                    pend[rid] <= 1'b0;
                    fill[rid] <= 1'b1;
                    data[rid] <= rdata;
                    serr[rid] <= CHK && rresp != 2'b00;
                end else begin
                    err <= 1'b1;
                end
                if (CHK && rresp != 2'b00) err <= 1'b1;
            end
            if (out_hs) begin
                fill[hs] <= 1'b0;
                head     <= head + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_array_alu_rd_master.sv
// tb_array_alu_rd_master: randomized AXI slave and in-order stream reference for array_alu_rd_master
module tb_array_alu_rd_master;
`ifdef ARRAY_ALU_RD_RRESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset, start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        busy, done, err;
    logic        arvalid, arready;
    logic [1:0]  arid;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [1:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int nvec = 0;
    int nerr = 0;

    array_alu_rd_master dut (
        .clk(clk), .areset(areset), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .err(err),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00A0A0A0;
    endfunction

    task automatic idle_inputs();
        start     = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = '0;
        out_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    // One command: the bench plays an AXI slave with a random return order and
    // checks every cycle against beat counters (issued / returned / streamed).
    task automatic run(input logic [31:0] b, input int n, input int par, input int pr,
                       input int po, input bit ordered, input int hold_r, input int hold_o,
                       input int pbad, input int perr, input int pstart);
        int         issued, streamed, cyc;
        int         outq[$];
        bit         ret[64];
        logic [1:0] bresp[64];
        bit         got_done, exp_err;
        issued = 0; streamed = 0; cyc = 0; got_done = 0; exp_err = 0;
        for (int i = 0; i < 64; i++) begin ret[i] = 0; bresp[i] = 2'b00; end
        @(negedge clk);
        start = 1'b1; base_addr = b; count = 16'(n);
        while (!got_done && cyc < 3000) begin
            logic [31:0] ea;
            int          k, beat, found, s0;
            @(negedge clk);
            cyc++;
            chk("busy", busy, 1);
            chk("rready", rready, 1);
            chk("done", done, streamed == n);
            chk("err", err, exp_err);
            chk("arvalid", arvalid, issued < n && issued - streamed < 4);
            if (arvalid) begin
                ea = b + 32'(issued) * 4;
                chk("araddr", araddr, ea);
                chk("arid", arid, issued % 4);
            end
            chk("out_valid", out_valid, streamed < n && ret[streamed]);
            if (out_valid && streamed < n) begin
                ea = mem(b + 32'(streamed) * 4);
                chk("out_data", out_data, ea);
                chk("out_err", out_err, CHK && bresp[streamed] != 2'b00);
            end
            if (done) begin
                got_done = 1;
                idle_inputs();
            end else begin
                start = pstart > 0 && $urandom_range(99) < pstart;
                base_addr = $urandom;
                count = 16'($urandom_range(0, 9));
                arready = $urandom_range(99) < par;
                rvalid = 1'b0;
                rresp = 2'b00;
                if (cyc > hold_r && outq.size() > 0 && $urandom_range(99) < pr) begin
                    k = ordered ? 0 : $urandom_range(outq.size() - 1);
                    beat = outq[k];
                    outq.delete(k);
                    rvalid = 1'b1;
                    rid = 2'(beat % 4);
                    rdata = mem(b + 32'(beat) * 4);
                    rresp = ($urandom_range(99) < perr) ? 2'b10 : 2'b00;
                    bresp[beat] = rresp;
                    ret[beat] = 1;
                    if (CHK && rresp != 2'b00) exp_err = 1;
                end else if (outq.size() < 4 && $urandom_range(99) < pbad) begin
                    found = -1;
                    s0 = $urandom_range(3);
                    for (int j = 0; j < 4; j++) begin
                        bit used;
                        used = 0;
                        foreach (outq[q]) if (outq[q] % 4 == (s0 + j) % 4) used = 1;
                        if (!used && found < 0) found = (s0 + j) % 4;
                    end
                    rvalid = 1'b1;
                    rid = 2'(found);
                    rdata = $urandom;
                    exp_err = 1;
                end
                out_ready = cyc > hold_o && $urandom_range(99) < po;
                if (arvalid && arready) begin
                    outq.push_back(issued);
                    issued++;
                end
                if (out_valid && out_ready) streamed++;
            end
        end
        if (!got_done) chk("timeout", 0, 1);
        @(negedge clk);
        check_quiet("after_done");
    endtask

    task automatic reset_mid_drain();
        @(negedge clk);
        start = 1'b1; base_addr = 32'h300; count = 16'd4;
        @(negedge clk);
        start = 1'b0; arready = 1'b1;
        repeat (6) @(negedge clk);
        arready = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_arvalid", arvalid, 0);
        rvalid = 1'b1; rid = 2'd0; rdata = 32'hDEAD0000; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        chk("drain_out_valid", out_valid, 1);
        chk("drain_out_data", out_data, 32'hDEAD0000);
        areset = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_araddr", araddr, 0);
        areset = 1'b0;
        rvalid = 1'b1; rid = 2'd1;
        @(negedge clk);
        rvalid = 1'b0;
        check_quiet("post_rst");
        chk("post_rst_err", err, 0);
    endtask

    initial begin
        areset = 1'b1;
        base_addr = '0;
        count = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_err", err, 0);
        chk("reset_arid", arid, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_err", out_err, 0);
        areset = 1'b0;
        // basic in-order read
        run(32'h100, 3, 100, 100, 100, 1, 0, 0, 0, 0, 0);
        // out-of-order returns
        run(32'h200, 4, 100, 100, 100, 0, 4, 0, 0, 0, 0);
        // window limit: no R for a while
        run(32'h1000, 8, 100, 100, 100, 1, 12, 0, 0, 0, 0);
        // zero count and address wrap
        run(32'h40, 0, 100, 100, 100, 0, 0, 0, 0, 0, 0);
        run(32'hFFFFFFFC, 2, 100, 100, 100, 0, 0, 0, 0, 0, 0);
        // stream backpressure
        run(32'h500, 6, 100, 100, 100, 0, 0, 10, 0, 0, 0);
        // error responses and unexpected ids
        run(32'h600, 5, 100, 60, 100, 0, 0, 0, 0, 50, 0);
        run(32'h700, 6, 70, 50, 80, 0, 0, 0, 40, 0, 0);
        for (int t = 0; t < 24; t++)
            run($urandom, $urandom_range(0, 30), $urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(20, 100), 1'b0, $urandom_range(0, 8), $urandom_range(0, 8),
                (t % 3 == 0) ? 15 : 0, (t % 2 == 0) ? 20 : 0, 10);
        reset_mid_drain();
        run(32'h800, 5, 100, 100, 100, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
